pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage LC-3b pipeline (IF, IF/ID, ID/EX, EX/MEM, MEM/WB). It watches instruction and data memory handshakes, load-use register hazards and MEM-stage control transfers. From these it drives per-register stall enables, a bubble-inject to ID/EX, and flushes. It also sequences the two data-memory accesses of LDI/STI and keeps saturating performance counters.

Parameters:
PERF_W, 16, width of the saturating stall and flush counters

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
if_req  in  1  IF stage has an outstanding instruction fetch
imem_resp  in  1  I-memory response pulse
dmem_req  in  1  MEM stage issuing a read or write
dmem_resp  in  1  D-memory response pulse
mem_indirect  in  1  MEM-stage instruction is LDI or STI (two accesses)
id_sr1  in  3  ID-stage source register 1
id_sr1_used  in  1  ID instruction reads sr1
id_sr2  in  3  ID-stage source register 2
id_sr2_used  in  1  ID instruction reads sr2
ex_dest  in  3  EX-stage destination register
ex_load  in  1  EX-stage instruction writes a register from memory (LDR/LDB/LDI)
br_taken_mem  in  1  MEM stage resolved a taken BR/JMP/JSR/TRAP
stall_if  out  1  hold PC/fetch
stall_if_id  out  1  hold IF/ID register
stall_id_ex  out  1  hold ID/EX register
stall_ex_mem  out  1  hold EX/MEM register
stall_mem_wb  out  1  hold MEM/WB register
bubble_id_ex  out  1  ID/EX loads all-zero (NOP) control word
flush_if_id  out  1  squash IF/ID contents
flush_id_ex  out  1  squash ID/EX contents
flush_ex_mem  out  1  squash EX/MEM contents
ind_phase  out  1  0 = indirect address access, 1 = final access
perf_stalls  out  PERF_W  cycles with any stall asserted
perf_flushes  out  PERF_W  flush events

Behaviour:
- Reset (sync): ind_phase, imem_done, dmem_done cleared; counters 0. All stall/bubble/flush outputs forced 0 during the reset cycle.
- i_ok = !if_req | imem_resp | imem_done.
- d_final = dmem_resp & (!mem_indirect | ind_phase).
- d_ok = !dmem_req | d_final | dmem_done.
- global_stall = !(i_ok & d_ok). When asserted, all five stall outputs are 1, no bubble and no flush.
- hazard = ex_load & ((id_sr1_used & id_sr1==ex_dest) | (id_sr2_used & id_sr2==ex_dest)).
- load_use = hazard & !global_stall & !br_taken_mem. Sets stall_if=stall_if_id=1 and bubble_id_ex=1. EX/MEM and MEM/WB advance. Exactly one bubble per hazard, because after the edge ex_load refers to the bubble.
- flush = br_taken_mem & !global_stall. Sets flush_if_id, flush_id_ex and flush_ex_mem for that cycle, with no stalls. Flush dominates load_use. A branch during global_stall waits; br_taken_mem stays held by the frozen MEM stage and the flush fires on the first unstalled cycle.
- Indirect FSM (ind_phase):
  - 0→1 on dmem_req & mem_indirect & dmem_resp & !ind_phase. This cycle still stalls.
  - 1→0 on the first cycle with ind_phase & !global_stall.
  - Reset mid-sequence returns to 0.
- Response latches:
  - imem_done is set on imem_resp & stall_if and cleared on the first cycle with stall_if=0.
  - dmem_done is set on d_final & global_stall and cleared on the first cycle with global_stall=0.
  - Response pulses arriving while their partner stage is blocked are not lost.
- Simultaneous imem_resp and d_final in the same cycle with no other blocker: no stall, no latch set.
- Counters:
  - perf_stalls increments on any cycle where any stall output is 1.
  - perf_flushes increments on each flush cycle.
  - Both saturate at all-ones (no wrap). Updated on the clock edge; not incremented in reset.
- All outputs except counters and ind_phase are combinational from inputs and internal state. Zero-latency decisions.

Test Plan:
- LDR R1 in EX, ID reads R1 as sr1 (no mem waits) → one cycle stall_if=stall_if_id=bubble_id_ex=1, stall_ex_mem=0; next cycle all 0.
- dmem_req=1 with resp after 3 cycles, if_req=0 → all stalls 1 for 3 cycles, 0 on the resp cycle; perf_stalls=3.
- LDI in MEM, resps at cycles 2 and 5 → ind_phase 0→1 after cycle 2; stalls through cycle 4; release on cycle 5; ind_phase back to 0.
- imem_resp arrives at cycle 1 while dmem waits until cycle 4 → imem_done=1 at cycles 2-4; release at cycle 4 without a second imem_resp.
- br_taken_mem=1 with dmem stall for 2 cycles → no flush for 2 cycles; flush of all three registers on cycle 3; perf_flushes=1.
- br_taken_mem and load-use hazard in the same cycle → flushes only, bubble_id_ex=0. perf_stalls saturates at 0xFFFF after forced long stall.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline.
// Combines memory handshakes, load-use hazards and MEM-stage control transfers
// into per-register stall enables, an ID/EX bubble and flushes. It also steps
// the two-access LDI/STI sequence and keeps saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic              imem_resp,
  input  logic              dmem_req,
  input  logic              dmem_resp,
  input  logic              mem_indirect,
  input  logic [2:0]        id_sr1,
  input  logic              id_sr1_used,
  input  logic [2:0]        id_sr2,
  input  logic              id_sr2_used,
  input  logic [2:0]        ex_dest,
  input  logic              ex_load,
  input  logic              br_taken_mem,
  output logic              stall_if,
  output logic              stall_if_id,
  output logic              stall_id_ex,
  output logic              stall_ex_mem,
  output logic              stall_mem_wb,
  output logic              bubble_id_ex,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              flush_ex_mem,
  output logic              ind_phase,
  output logic [PERF_W-1:0] perf_stalls,
  output logic [PERF_W-1:0] perf_flushes
);

  logic              ind_phase_q, ind_phase_d;
  logic              imem_done_q, imem_done_d;
  logic              dmem_done_q, dmem_done_d;
  logic [PERF_W-1:0] perf_stalls_q, perf_stalls_d;
  logic [PERF_W-1:0] perf_flushes_q, perf_flushes_d;

  logic i_ok, d_final, d_ok, global_stall, hazard, load_use, flush_evt;
  logic any_stall;

  // Raw hazard conditions derived from handshakes, latched responses and register ids.
  always_comb begin
    i_ok         = !if_req | imem_resp | imem_done_q;
    // The first access of an indirect instruction only yields an address, so it
    // does not complete the MEM stage.
    d_final      = dmem_resp & (!mem_indirect | ind_phase_q);
    d_ok         = !dmem_req | d_final | dmem_done_q;
    global_stall = !(i_ok & d_ok);
    hazard       = ex_load & ((id_sr1_used & (id_sr1 == ex_dest)) |
                              (id_sr2_used & (id_sr2 == ex_dest)));
    // A taken branch squashes the dependent ID instruction, so no bubble is needed.
    load_use     = hazard & !global_stall & !br_taken_mem;
    flush_evt    = br_taken_mem & !global_stall;
  end

  // Priority-encode the pipeline controls: memory wait, then flush, then load-use.
  always_comb begin
    stall_if     = 1'b0;
    stall_if_id  = 1'b0;
    stall_id_ex  = 1'b0;
    stall_ex_mem = 1'b0;
    stall_mem_wb = 1'b0;
    bubble_id_ex = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    if (!reset) begin
      if (global_stall) begin
        stall_if     = 1'b1;
        stall_if_id  = 1'b1;
        stall_id_ex  = 1'b1;
        stall_ex_mem = 1'b1;
        stall_mem_wb = 1'b1;
      end else if (flush_evt) begin
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
      end else if (load_use) begin
        stall_if     = 1'b1;
        stall_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end
    end
  end

  // Next-state for the indirect phase, response latches and saturating counters.
  always_comb begin
    ind_phase_d = ind_phase_q;
    if (!ind_phase_q && dmem_req && mem_indirect && dmem_resp) begin
      ind_phase_d = 1'b1;
    end else if (ind_phase_q && !global_stall) begin
      ind_phase_d = 1'b0;
    end

    // Remember a response that arrived while the pipeline was held, so the
    // stage does not wait for a second pulse that will never come.
    imem_done_d = stall_if ? (imem_done_q | imem_resp) : 1'b0;
    dmem_done_d = global_stall ? (dmem_done_q | d_final) : 1'b0;

    any_stall = stall_if | stall_if_id | stall_id_ex | stall_ex_mem | stall_mem_wb;

    perf_stalls_d = perf_stalls_q;
    if (any_stall && (perf_stalls_q != {PERF_W{1'b1}})) begin
      perf_stalls_d = perf_stalls_q + PERF_W'(1);
    end

    perf_flushes_d = perf_flushes_q;
    if (flush_if_id && (perf_flushes_q != {PERF_W{1'b1}})) begin
      perf_flushes_d = perf_flushes_q + PERF_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ind_phase_q    <= 1'b0;
      imem_done_q    <= 1'b0;
      dmem_done_q    <= 1'b0;
      perf_stalls_q  <= '0;
      perf_flushes_q <= '0;
    end else begin
      ind_phase_q    <= ind_phase_d;
      imem_done_q    <= imem_done_d;
      dmem_done_q    <= dmem_done_d;
      perf_stalls_q  <= perf_stalls_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign ind_phase    = ind_phase_q;
  assign perf_stalls  = perf_stalls_q;
  assign perf_flushes = perf_flushes_q;

endmodule
